photo_index_ctrl: RTL

- Upstream of the two-digit 7-segment driver in the photo frame; turns user buttons and an auto-slideshow timer into the current photo index.
- Debounces next/prev/auto keys, keeps a wrapping 0-based index for the image ROM and a 1-based display byte for the segment driver's 8-bit data input.
- Flags every index change with a one-cycle pulse.

---
 rtl/photo_index_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/photo_index_ctrl.sv
// photo_index_ctrl
//   Turns the next/prev/auto buttons and an auto-slideshow timer into the
//   current photo index. The index goes to the image ROM, and a 1-based
//   display byte goes to the two-digit 7-segment driver.
//
// Ports
//   i_clk      : system clock. All logic runs on the rising edge.
//   i_rst_n    : asynchronous active-low reset.
//   i_key_next : raw button, advance one photo.
//   i_key_prev : raw button, go back one photo.
//   i_key_auto : raw button, toggle slideshow mode.
//   o_sel      : 0-based photo index, 0..NUM_PHOTOS-1.
//   o_data     : display value of o_sel+1.
//   o_changed  : one-cycle pulse on every index step request.
//   o_auto     : high while slideshow mode is active.
//
// Build option
//   PHOTO_INDEX_BCD_EN : when defined, o_data is two BCD digits
//   ({tens, ones}). Otherwise o_data is plain binary.
module photo_index_ctrl #(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int SLIDE_SEC      = 3,
  parameter int NUM_PHOTOS     = 16,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_next,
  input  logic       i_key_prev,
  input  logic       i_key_auto,
  output logic [7:0] o_sel,
  output logic [7:0] o_data,
  output logic       o_changed,
  output logic       o_auto
);

  localparam int DB_CYCLES    = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int SLIDE_CYCLES = CLK_FREQ_HZ * SLIDE_SEC;
  localparam int DBW          = $clog2(DB_CYCLES + 1);
  localparam int SLW          = $clog2(SLIDE_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
  localparam logic [SLW-1:0] SL_LAST  = SLW'(SLIDE_CYCLES - 1);
  localparam logic [SLW-1:0] SL_ONE   = SLW'(1);
  localparam logic [7:0]     LAST_IDX = 8'(NUM_PHOTOS - 1);

  // Pin level of a key that is not pressed. The synchronisers reset to this
  // level, so after reset every key is seen as released.
  localparam logic REL_LEVEL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [2:0] w_key_raw;
  logic [2:0] w_evt;
  assign w_key_raw = {i_key_auto, i_key_prev, i_key_next};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic           r_sync1;
      logic           r_sync2;
      logic [1:0]     r_state;
      logic [DBW-1:0] r_cnt;
      logic           r_evt;
      logic           w_pressed;

      // Normalise the key polarity: w_pressed is 1 whenever the key is down.
      assign w_pressed = r_sync2 ^ REL_LEVEL;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sync1 <= REL_LEVEL;
          r_sync2 <= REL_LEVEL;
          r_state <= ST_RELEASED;
          r_cnt   <= '0;
          r_evt   <= 1'b0;
        end else begin
          r_sync1 <= w_key_raw[gi];
          r_sync2 <= r_sync1;
          r_evt   <= 1'b0;
          case (r_state)
            ST_RELEASED: begin
              if (w_pressed) begin
                r_state <= ST_PRESS_WAIT;
                r_cnt   <= '0;
              end
            end
            ST_PRESS_WAIT: begin
              if (!w_pressed) begin
                r_state <= ST_RELEASED;
              end else if (r_cnt == DB_LAST) begin
                r_state <= ST_PRESSED;
                r_evt   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + DB_ONE;
              end
            end
            ST_PRESSED: begin
              if (!w_pressed) begin
                r_state <= ST_RELEASE_WAIT;
                r_cnt   <= '0;
              end
            end
            default: begin
              // A press during the release wait counts as the same hold, so
              // it goes back to PRESSED without a new event.
              if (w_pressed) begin
                r_state <= ST_PRESSED;
              end else if (r_cnt == DB_LAST) begin
                r_state <= ST_RELEASED;
              end else begin
                r_cnt <= r_cnt + DB_ONE;
              end
            end
          endcase
        end
      end

      assign w_evt[gi] = r_evt;
    end
  endgenerate

  logic           r_auto;
  logic [SLW-1:0] r_timer;
  logic [7:0]     r_sel;
  logic [7:0]     r_data;
  logic           r_changed;

  logic       w_next;
  logic       w_prev;
  logic       w_auto_evt;
  logic       w_tick;
  logic       w_fwd;
  logic       w_back;
  logic [7:0] w_sel_next;
  logic [7:0] w_disp;
  logic [7:0] w_data_next;

  assign w_next     = w_evt[0];
  assign w_prev     = w_evt[1];
  assign w_auto_evt = w_evt[2];
  assign w_tick     = r_auto && (r_timer == SL_LAST);

  // A manual key always wins over the tick. Next and prev together cancel
  // each other, and they also suppress a tick in the same cycle.
  assign w_fwd  = (w_next & ~w_prev) | (w_tick & ~w_next & ~w_prev);
  assign w_back = w_prev & ~w_next;

  always_comb begin
    w_sel_next = r_sel;
    if (w_fwd) begin
      w_sel_next = (r_sel == LAST_IDX) ? 8'd0 : r_sel + 8'd1;
    end else if (w_back) begin
      w_sel_next = (r_sel == 8'd0) ? LAST_IDX : r_sel - 8'd1;
    end
  end

  // The display code is built from the next index, so o_data moves in the
  // same cycle as o_sel.
  assign w_disp = w_sel_next + 8'd1;
`ifdef PHOTO_INDEX_BCD_EN
  assign w_data_next = 8'(((w_disp / 8'd10) << 4) | (w_disp % 8'd10));
`else
  assign w_data_next = w_disp;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_auto    <= 1'b0;
      r_timer   <= '0;
      r_sel     <= 8'd0;
      r_data    <= 8'h01;
      r_changed <= 1'b0;
    end else begin
      r_sel     <= w_sel_next;
      r_data    <= w_data_next;
      r_changed <= w_fwd | w_back;
      if (w_auto_evt) begin
        r_auto <= ~r_auto;
      end
      // The timer restarts on a mode toggle, on any manual step and on its
      // own wrap. It is held at 0 while slideshow mode is off.
      if (w_auto_evt || !r_auto || w_next || w_prev || w_tick) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + SL_ONE;
      end
    end
  end

  assign o_sel     = r_sel;
  assign o_data    = r_data;
  assign o_changed = r_changed;
  assign o_auto    = r_auto;

endmodule
